// File: rtl/multu_seq_unit.sv
// Iterative unsigned WIDTH x WIDTH multiplier with HI/LO result registers. It computes
// one shift-add step per clock and holds the pipeline through busy until HI/LO are valid.
module multu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] step;
    logic             accept;

    // Handshake: start is sampled on the rising edge and is accepted only in IDLE or DONE.
    // busy is high for the WIDTH RUN cycles. done pulses for one cycle with HI/LO already valid.
    // Both outputs decode the state register only, so start has no combinational path to them.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        prod_lo_d = prod_lo_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        sum    = prod_lo_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
        step   = {sum, prod_lo_q} >> 1;
        accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        case (state_q)
            ST_RUN: begin
                acc_d     = step[2*WIDTH:WIDTH];
                prod_lo_d = step[WIDTH-1:0];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = step[2*WIDTH-1:WIDTH];
                    lo_d    = step[WIDTH-1:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A DONE-cycle start reloads the operands directly, so back-to-back issue has no bubble.
        if (accept) begin
            mcand_d   = dataA;
            acc_d     = '0;
            prod_lo_d = dataB;
            cnt_d     = CW'(WIDTH);
            state_d   = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            prod_lo_q <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            prod_lo_q <= prod_lo_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multu_seq_unit.sv
// Bench for multu_seq_unit: random and directed multiplies checked against a plain
// 64-bit product model, plus latency, back-to-back issue and reset-abort behaviour.
module tb_multu_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data_a, data_b;
    logic         busy, done;
    logic [W-1:0] hi_out, lo_out;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*W-1:0] exp_q[$];

    multu_seq_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dataA       (data_a),
        .dataB       (data_b),
        .busy        (busy),
        .done        (done),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa, wb;
        wa = {32'b0, a};
        wb = {32'b0, b};
        return wa * wb;
    endfunction

    // Called at a negedge while the unit is idle or in its done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                          input string tag);
        logic [63:0] prev;
        logic [63:0] exp;
        int busy_n;
        bit seen;
        busy_n = 0;
        seen   = 1'b0;
        prev   = {hi_out, lo_out};
        start  = 1'b1;
        data_a = a;
        data_b = b;
        exp_q.push_back(ref_mul(a, b));
        @(posedge clk);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, "_accept_busy"}, 64'(busy), 64'd1);
            check({tag, "_excl"}, 64'(busy & done), 64'd0);
            if (busy) begin
                busy_n++;
                check({tag, "_hilo_hold"}, {hi_out, lo_out}, prev);
                if (scramble && busy_n < 20) begin
                    start  = (busy_n == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                    data_a = (busy_n == 2) ? 32'd7 : $urandom;
                    data_b = (busy_n == 2) ? 32'd9 : $urandom;
                end else begin
                    start = 1'b0;
                end
            end
            if (done) seen = 1'b1;
        end
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        exp = exp_q.pop_front();
        check({tag, "_product"}, {hi_out, lo_out}, exp);
    endtask

    task automatic idle_check(input int n, input logic [63:0] exp_hilo, input string tag);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 64'(busy), 64'd0);
            check({tag, "_done"}, 64'(done), 64'd0);
            check({tag, "_hilo"}, {hi_out, lo_out}, exp_hilo);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        rst    = 1'b0;
        start  = 1'b0;
        data_a = '0;
        data_b = '0;

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_done", 64'(done), 64'd0);
        check("rst_async_hilo", {hi_out, lo_out}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_check(5, 64'd0, "post_rst");

        run_op(32'd3, 32'd5, 1'b0, "mul_3x5");
        check("mul_3x5_const", {hi_out, lo_out}, 64'h0000_0000_0000_000F);
        idle_check(10, 64'h0000_0000_0000_000F, "hold_3x5");

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "carry");
        check("carry_const", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
        idle_check(1, 64'hFFFF_FFFE_0000_0001, "carry_idle");

        run_op(32'h0001_0000, 32'h0001_0000, 1'b1, "ignored");
        check("ignored_const", {hi_out, lo_out}, 64'h0000_0001_0000_0000);
        idle_check(3, 64'h0000_0001_0000_0000, "no_second_op");

        run_op(32'd2, 32'd3, 1'b0, "b2b_first");
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "b2b_second");
        check("b2b_const", {hi_out, lo_out}, 64'h0B00_EA4E_242D_2080);
        idle_check(1, 64'h0B00_EA4E_242D_2080, "b2b_idle");

        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            b = (k == 3) ? 32'd0 : $urandom;
            if (k == 5) a = 32'd0;
            run_op(a, b, k[0], "rand");
            if (k >= 6) continue;
            idle_check(1, ref_mul(a, b), "rand_idle");
        end
        idle_check(1, ref_mul(a, b), "rand_tail");

        run_op(32'd2, 32'd2, 1'b0, "mul_2x2");
        idle_check(1, 64'd4, "mul_2x2_idle");

        // Start 100 x 100, then reset shortly after the tenth RUN edge.
        start  = 1'b1;
        data_a = 32'd100;
        data_b = 32'd100;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_pre", 64'(busy), 64'd1);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi_out, lo_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_check(4, 64'd0, "abort_idle");

        run_op(32'd6, 32'd7, 1'b0, "mul_6x7");
        check("mul_6x7_const", {hi_out, lo_out}, 64'd42);
        idle_check(2, 64'd42, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multu_seq_unit.md
# multu_seq_unit

Iterative unsigned 32x32 multiplier with integrated HI/LO result registers, instantiated in the EX stage of the five-stage MIPS pipeline. It accepts a `multu` from EX, computes the 64-bit product with one shift-add step per cycle, and writes the result into HI/LO. It asserts `busy` so the hazard logic can freeze PC, IF/ID and ID/EX until `mfhi`/`mflo` can safely read the result.

## Interface

Parameters:
- `WIDTH`, default 32. Operand width. The product is 2*WIDTH. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high. Clears all state immediately.
- `start`  in  1  request a multiply; sampled on the rising edge; honoured only in IDLE or DONE.
- `dataA`  in  WIDTH  multiplicand (EX rs value); captured at the accepting edge only.
- `dataB`  in  WIDTH  multiplier (EX rt value); captured at the accepting edge only.
- `busy`  out  1  high while state = RUN; drives the pipeline stall.
- `done`  out  1  one-cycle pulse, high while state = DONE.
- `hi_out`  out  WIDTH  HI register, upper half of the last completed product.
- `lo_out`  out  WIDTH  LO register, lower half of the last completed product.

## Operation

- State machine states: IDLE, RUN, DONE. Encoding is free.
- Internal registers:
  - `mcand` (WIDTH)
  - `acc` (WIDTH+1, holds the carry)
  - `prod_lo` (WIDTH)
  - `cnt`, sized to hold 0..WIDTH
  - `hi`, `lo`
- IDLE, `start`=1:
  - `mcand`<=`dataA`, `acc`<=0, `prod_lo`<=`dataB`, `cnt`<=WIDTH.
  - Go to RUN.
- IDLE, `start`=0: hold.
- RUN, each cycle:
  - If `prod_lo[0]`=1, sum = `acc`+`mcand`; otherwise sum = `acc`.
  - Then {`acc`,`prod_lo`} <= {1'b0, sum, `prod_lo`} >> 1, i.e. the (2*WIDTH+1)-bit value shifted right by 1.
  - `cnt`<=`cnt`-1.
- RUN, last step (`cnt`=1):
  - Also load `hi`<= upper WIDTH bits and `lo`<= lower WIDTH bits of the final shifted product.
  - Go to DONE.
- DONE: `done`=1 for exactly this cycle.
  - `start`=1: accept the new operands exactly as in IDLE and go to RUN (back-to-back issue, no bubble).
  - `start`=0: go to IDLE.
- `start` during RUN is ignored. It is neither queued nor restarting. Operand changes during RUN have no effect.
- Arithmetic is unsigned modulo 2^(2*WIDTH), with no overflow flag. Zero operands still take the full WIDTH iterations; there is no early-out.
- HI/LO change only on the RUN-to-DONE edge or on reset. They hold indefinitely otherwise, including across IDLE and a new RUN.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `hi_out`=0, `lo_out`=0, and all internal registers 0. This takes effect asynchronously on `rst` assertion.
- Reset mid-RUN aborts the operation and clears HI/LO. The first edge after deassertion behaves as IDLE.
- Let E0 be the edge that accepts `start`:
  - `busy`=1 from E0 to E`WIDTH`.
  - E`WIDTH` loads HI/LO.
  - `done`=1 from E`WIDTH` to E`WIDTH`+1.
  - The product is visible on `hi_out`/`lo_out` in the cycle `done` is high, i.e. latency WIDTH+1 edges after `start` is presented. This is 32 busy cycles for WIDTH=32.
- `busy` and `done` are never high together.
- `busy` and `done` are pure decodes of the state register, with no combinational path from `start`. This avoids a stall loop with the hazard unit.
- The hazard unit must also stall on `start` in the issue cycle if a dependent `mfhi`/`mflo` follows. That behaviour belongs to the hazard unit, not to this block.

## Test plan

- Reset:
  - Assert `rst` mid-cycle with no clock: `hi_out`=`lo_out`=0, `busy`=0, `done`=0 immediately.
  - Deassert, idle for 5 cycles: outputs stay 0.
- Basic multiply, 3 x 5:
  - `start` for one cycle: `busy` high for exactly 32 cycles.
  - Then `done` high for exactly 1 cycle with `hi_out`=0x00000000, `lo_out`=0x0000000F.
  - Values hold for 10 further idle cycles.
- Carry path, 0xFFFFFFFF x 0xFFFFFFFF: `hi_out`=0xFFFFFFFE, `lo_out`=0x00000001.
- Ignored inputs, 0x00010000 x 0x00010000:
  - Re-pulse `start` with 7 x 9 and change `dataA`/`dataB` randomly during RUN.
  - Result `hi_out`=0x00000001, `lo_out`=0x00000000, completing at E32. No second operation starts.
- Back-to-back:
  - Hold `start` through the DONE cycle with 0x12345678 x 0x9ABCDEF0.
  - `busy` rises on the next edge with no IDLE cycle.
  - Second result `hi_out`=0x0B00EA4E, `lo_out`=0x242D2080. The first result remains on HI/LO until then.
- Reset mid-operation:
  - Complete 2 x 2 (`lo_out`=4).
  - Start 100 x 100 and assert `rst` at E10: HI/LO read 0, `busy`=0, no `done` pulse.
  - After release, 6 x 7 gives `lo_out`=42 at E32.
